// File: rtl/cpu_sequencer.sv
// Multi-cycle instruction sequencer: fetch words, load operands, calculate, store,
// with an IO wait timeout that parks the machine in ERROR until software restarts it.
module cpu_sequencer #(
    parameter int FETCH_WORDS = 1,
    parameter int MAX_LOADS   = 2,
    parameter int TIMEOUT     = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] cmd,
    input  logic       ready,
    input  logic       run,
    output logic [3:0] cpu_state,
    output logic [2:0] word_idx,
    output logic       timeout_err
);

    typedef enum logic [3:0] {
        FETCH_BEGIN = 4'd0,
        FETCH_IO    = 4'd1,
        FETCH_END   = 4'd2,
        EXEC_BEGIN  = 4'd3,
        LOAD_BEGIN  = 4'd4,
        LOAD_IO     = 4'd5,
        LOAD_END    = 4'd6,
        CALC        = 4'd7,
        STORE_BEGIN = 4'd8,
        STORE_IO    = 4'd9,
        HALT        = 4'd10,
        ERROR       = 4'd11
    } state_t;

    localparam logic [2:0]  LAST_WORD = 3'(FETCH_WORDS - 1);
    localparam logic [2:0]  MAX_N     = 3'(MAX_LOADS);
    localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

    state_t      state;
    logic [15:0] wait_cnt;
    logic [2:0]  n_loads;
    logic        store_q;
    logic        halt_q;
    logic [2:0]  n_eff;
    logic        wait_expired;

    assign n_eff        = (cmd[2:0] > MAX_N) ? MAX_N : cmd[2:0];
    assign wait_expired = (wait_cnt == WAIT_LAST);
    assign cpu_state    = state;

    // ready is a completion strobe sampled only in *_IO states: ready=1 on a clock
    // edge ends the transfer, and it wins over a wait counter expiring on that edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= FETCH_BEGIN;
            word_idx    <= 3'd0;
            timeout_err <= 1'b0;
            wait_cnt    <= 16'd0;
            n_loads     <= 3'd0;
            store_q     <= 1'b0;
            halt_q      <= 1'b0;
        end else begin
            case (state)
                FETCH_BEGIN: begin
                    state    <= FETCH_IO;
                    wait_cnt <= 16'd0;
                end
                FETCH_IO: begin
                    if (ready) begin
                        state <= FETCH_END;
                    end else if (wait_expired) begin
                        state       <= ERROR;
                        word_idx    <= 3'd0;
                        timeout_err <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                FETCH_END: begin
                    if (word_idx < LAST_WORD) begin
                        state    <= FETCH_BEGIN;
                        word_idx <= word_idx + 3'd1;
                    end else begin
                        state    <= EXEC_BEGIN;
                        word_idx <= 3'd0;
                    end
                end
                EXEC_BEGIN: begin
                    n_loads  <= n_eff;
                    store_q  <= cmd[3];
                    halt_q   <= cmd[4];
                    word_idx <= 3'd0;
                    state    <= (n_eff != 3'd0) ? LOAD_BEGIN : CALC;
                end
                LOAD_BEGIN: begin
                    state    <= LOAD_IO;
                    wait_cnt <= 16'd0;
                end
                LOAD_IO: begin
                    if (ready) begin
                        state <= LOAD_END;
                    end else if (wait_expired) begin
                        state       <= ERROR;
                        word_idx    <= 3'd0;
                        timeout_err <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                LOAD_END: begin
                    // widened compare keeps n_loads-1 from wrapping
                    if (({1'b0, word_idx} + 4'd1) < {1'b0, n_loads}) begin
                        state    <= LOAD_BEGIN;
                        word_idx <= word_idx + 3'd1;
                    end else begin
                        state    <= CALC;
                        word_idx <= 3'd0;
                    end
                end
                CALC: begin
                    word_idx <= 3'd0;
                    if (store_q) state <= STORE_BEGIN;
                    else         state <= halt_q ? HALT : FETCH_BEGIN;
                end
                STORE_BEGIN: begin
                    state    <= STORE_IO;
                    wait_cnt <= 16'd0;
                end
                STORE_IO: begin
                    if (ready) begin
                        state    <= halt_q ? HALT : FETCH_BEGIN;
                        word_idx <= 3'd0;
                    end else if (wait_expired) begin
                        state       <= ERROR;
                        word_idx    <= 3'd0;
                        timeout_err <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                HALT: begin
                    if (run) begin
                        state    <= FETCH_BEGIN;
                        word_idx <= 3'd0;
                    end
                end
                ERROR: begin
                    if (run) begin
                        state       <= FETCH_BEGIN;
                        word_idx    <= 3'd0;
                        timeout_err <= 1'b0;
                    end
                end
                default: begin
                    state    <= FETCH_BEGIN;
                    word_idx <= 3'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: one instance at default parameters and one with
// two fetch words and a short timeout, each checked cycle by cycle against a queue.
module tb_cpu_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_a, ready_a, run_a;
    logic [4:0] cmd_a;
    logic [3:0] state_a;
    logic [2:0] idx_a;
    logic       err_a;

    logic       reset_b, ready_b, run_b;
    logic [4:0] cmd_b;
    logic [3:0] state_b;
    logic [2:0] idx_b;
    logic       err_b;

    cpu_sequencer dut_a (
        .clk        (clk),
        .reset      (reset_a),
        .cmd        (cmd_a),
        .ready      (ready_a),
        .run        (run_a),
        .cpu_state  (state_a),
        .word_idx   (idx_a),
        .timeout_err(err_a)
    );

    cpu_sequencer #(
        .FETCH_WORDS(2),
        .MAX_LOADS  (2),
        .TIMEOUT    (4)
    ) dut_b (
        .clk        (clk),
        .reset      (reset_b),
        .cmd        (cmd_b),
        .ready      (ready_b),
        .run        (run_b),
        .cpu_state  (state_b),
        .word_idx   (idx_b),
        .timeout_err(err_b)
    );

    int checks = 0;
    int errors = 0;
    // expected {timeout_err, cpu_state, word_idx} per clock
    logic [7:0] exp_q[$];

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push(input int st, input int idx, input int err);
        exp_q.push_back({1'(err), 4'(st), 3'(idx)});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // one edge per queued entry, compared 1ns after the edge
    task automatic drain(input bit use_b, input string tag);
        logic [7:0] e;
        logic [7:0] got;
        int n;
        n = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tick();
            got = use_b ? {err_b, state_b, idx_b} : {err_a, state_a, idx_a};
            check($sformatf("%s[%0d]", tag, n), {8'd0, got}, {8'd0, e});
            n++;
        end
    endtask

    initial begin
        reset_a = 1'b0; cmd_a = 5'd0; ready_a = 1'b0; run_a = 1'b0;
        reset_b = 1'b0; cmd_b = 5'd0; ready_b = 1'b0; run_b = 1'b0;
        tick();
        tick();
        check("a_reset_state", {12'd0, state_a}, 16'd0);
        check("a_reset_idx",   {13'd0, idx_a},   16'd0);
        check("a_reset_err",   {15'd0, err_a},   16'd0);
        check("b_reset_state", {12'd0, state_b}, 16'd0);

        // defaults, cmd=0, ready=1; run held high to show it is ignored here
        reset_a = 1'b1; ready_a = 1'b1; run_a = 1'b1;
        for (int r = 0; r < 2; r++) begin
            push(1, 0, 0); push(2, 0, 0); push(3, 0, 0); push(7, 0, 0); push(0, 0, 0);
        end
        drain(1'b0, "a_basic");
        run_a = 1'b0;

        // 7 requested loads clamp to MAX_LOADS=2
        cmd_a = 5'b00111;
        push(1, 0, 0); push(2, 0, 0); push(3, 0, 0);
        push(4, 0, 0); push(5, 0, 0); push(6, 0, 0);
        push(4, 1, 0); push(5, 1, 0); push(6, 1, 0);
        push(7, 0, 0); push(0, 0, 0);
        drain(1'b0, "a_clamp");

        // halt after CALC, hold for 10 cycles, leave on run pulse
        cmd_a = 5'b10000;
        push(1, 0, 0); push(2, 0, 0); push(3, 0, 0); push(7, 0, 0); push(10, 0, 0);
        for (int h = 0; h < 10; h++) push(10, 0, 0);
        drain(1'b0, "a_halt");
        run_a = 1'b1;
        cmd_a = 5'd0;
        push(0, 0, 0);
        drain(1'b0, "a_run");
        run_a = 1'b0;

        // async reset in the second LOAD_IO, between edges
        cmd_a = 5'b00010;
        push(1, 0, 0); push(2, 0, 0); push(3, 0, 0);
        push(4, 0, 0); push(5, 0, 0); push(6, 0, 0);
        push(4, 1, 0); push(5, 1, 0);
        drain(1'b0, "a_pre_rst");
        #2;
        reset_a = 1'b0;
        #1;
        check("a_async_state", {12'd0, state_a}, 16'd0);
        check("a_async_idx",   {13'd0, idx_a},   16'd0);
        check("a_async_err",   {15'd0, err_a},   16'd0);
        tick();
        reset_a = 1'b1;
        push(1, 0, 0);
        drain(1'b0, "a_post_rst");

        // FETCH_WORDS=2, two loads and a store
        reset_b = 1'b1; cmd_b = 5'b01010; ready_b = 1'b1;
        push(1, 0, 0); push(2, 0, 0); push(0, 1, 0); push(1, 1, 0); push(2, 1, 0);
        push(3, 0, 0); push(4, 0, 0); push(5, 0, 0); push(6, 0, 0);
        push(4, 1, 0); push(5, 1, 0); push(6, 1, 0);
        push(7, 0, 0); push(8, 0, 0); push(9, 0, 0); push(0, 0, 0);
        drain(1'b1, "b_store");

        // TIMEOUT=4: four FETCH_IO cycles without ready, then ERROR
        ready_b = 1'b0; cmd_b = 5'd0;
        push(1, 0, 0); push(1, 0, 0); push(1, 0, 0); push(1, 0, 0);
        push(11, 0, 1);
        drain(1'b1, "b_timeout");
        ready_b = 1'b1;
        push(11, 0, 1); push(11, 0, 1);
        drain(1'b1, "b_err_hold");
        run_b = 1'b1;
        push(0, 0, 0);
        drain(1'b1, "b_err_run");
        run_b = 1'b0;

        // ready arriving on the last allowed cycle wins over the timeout
        ready_b = 1'b0;
        push(1, 0, 0); push(1, 0, 0); push(1, 0, 0); push(1, 0, 0);
        drain(1'b1, "b_late_wait");
        ready_b = 1'b1;
        push(2, 0, 0); push(0, 1, 0);
        drain(1'b1, "b_late_ready");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cpu_sequencer.md
CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
REQ-001 Parameter FETCH_WORDS, default 1: instruction words per fetch, range 1..4.
REQ-002 Parameter MAX_LOADS, default 2: maximum operand loads per instruction, range 1..7.
REQ-003 Parameter TIMEOUT, default 255: maximum cycles an IO state waits for ready, range 2..65535.
REQ-004 Port clk, input, 1: single clock; all state changes on its rising edge.
REQ-005 Port reset, input, 1: asynchronous, active-low reset (0 = reset asserted).
REQ-006 Port cmd, input, 5: decoded instruction. [2:0] = load count; [3] = store; [4] = halt.
REQ-007 Port ready, input, 1: external IO done; meaningful only in the *_IO states.
REQ-008 Port run, input, 1: single-cycle pulse; leaves HALT or ERROR.
REQ-009 Port cpu_state, output, 4: current state code.
REQ-010 Port word_idx, output, 3: current fetch word index or load index.
REQ-011 Port timeout_err, output, 1: sticky flag; set on an IO timeout.

Function
REQ-012 State codes SHALL be: FETCH_BEGIN=0, FETCH_IO=1, FETCH_END=2, EXEC_BEGIN=3, LOAD_BEGIN=4, LOAD_IO=5, LOAD_END=6, CALC=7, STORE_BEGIN=8, STORE_IO=9, HALT=10, ERROR=11.
REQ-013 Fetch path SHALL be FETCH_BEGIN->FETCH_IO, then FETCH_IO->FETCH_END once ready=1 is sampled.
REQ-014 FETCH_END SHALL go to FETCH_BEGIN with word_idx+1 while word_idx<FETCH_WORDS-1; otherwise it SHALL go to EXEC_BEGIN.
REQ-015 EXEC_BEGIN SHALL latch the effective load count n = min(cmd[2:0], MAX_LOADS), cmd[3] and cmd[4]; it SHALL go to LOAD_BEGIN with word_idx=0 if n>0, else to CALC.
REQ-016 Load path SHALL be LOAD_BEGIN->LOAD_IO, then LOAD_IO->LOAD_END once ready=1 is sampled.
REQ-017 LOAD_END SHALL go to LOAD_BEGIN with word_idx+1 while word_idx<n-1; otherwise it SHALL go to CALC.
REQ-018 CALC SHALL go to STORE_BEGIN if the latched store bit is 1, else to the post-instruction target.
REQ-019 Store path SHALL be STORE_BEGIN->STORE_IO, then STORE_IO->post-instruction target once ready=1 is sampled.
REQ-020 Post-instruction target SHALL be HALT if the latched halt bit is 1, else FETCH_BEGIN with word_idx=0.
REQ-021 HALT SHALL hold until run=1 is sampled, then go to FETCH_BEGIN with word_idx=0.
REQ-022 cmd SHALL be ignored in every state except EXEC_BEGIN.
REQ-023 A 16-bit wait counter SHALL clear on entry to each *_IO state and increment each cycle in that state without ready.
REQ-024 If the wait counter reaches TIMEOUT-1 with ready=0, the next state SHALL be ERROR and timeout_err SHALL be set.
REQ-025 ready=1 on the same cycle the counter reaches TIMEOUT-1 SHALL take precedence: normal transition, no error.
REQ-026 ERROR SHALL hold until run=1, then go to FETCH_BEGIN with word_idx=0 and clear timeout_err.
REQ-027 run SHALL be ignored outside HALT and ERROR.
REQ-028 An unused state code SHALL go to FETCH_BEGIN with word_idx=0 on the next edge.
REQ-029 word_idx SHALL stay 0 in all states other than the fetch and load states.
REQ-030 All outputs SHALL be registered.

Reset
REQ-031 While reset=0, outputs SHALL be cpu_state=0, word_idx=0, timeout_err=0, and the wait counter and latched cmd fields SHALL be 0, regardless of clk.
REQ-032 Reset asserted mid-operation, including in IO, HALT or ERROR, SHALL abort immediately to the reset values.
REQ-033 After reset=1, the first edge SHALL move cpu_state to FETCH_IO.

Verification
REQ-034 Defaults; cmd=0; ready=1 in all IO states -> state sequence 0,1,2,3,7,0 repeating.
REQ-035 FETCH_WORDS=2; cmd=5'b01010 (2 loads, store); ready=1 -> states 0,1,2,0,1,2,3,4,5,6,4,5,6,7,8,9,0; word_idx 0,0,0,1,1,1,0,0,0,0,1,1,1,0...
REQ-036 cmd[2:0]=7 with MAX_LOADS=2 -> exactly 2 load passes.
REQ-037 cmd[4]=1; ready=1 -> HALT after CALC; HALT holds 10 cycles; run pulse -> FETCH_BEGIN.
REQ-038 TIMEOUT=4; ready=0 in FETCH_IO -> ERROR after 4 FETCH_IO cycles and timeout_err=1. Second case: ready=1 on the 4th FETCH_IO cycle -> FETCH_END and no error.
REQ-039 reset=0 asserted asynchronously mid LOAD_IO -> outputs zero before the next edge.
